sync_debounce: RTL and testbench



---
 rtl/sync_debounce.sv | 128 ++++++++++++
 tb/tb_sync_debounce.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// Two-flop synchronizer plus four-state debounce FSM for a raw async input.
// Define SYNC_DEBOUNCE_EDGE_EN to build the registered rise/fall pulses.
module sync_debounce #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   typedef enum logic [1:0] {
      STABLE_LOW,
      WAIT_HIGH,
      STABLE_HIGH,
      WAIT_LOW
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam bit ONE_SHOT = (STABLE_CYCLES == 1);

   logic             s1;
   logic             s2;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             to_high;
   logic             to_low;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
      end
   end

   // Edges on which the filtered level is about to change.
   always_comb begin
      to_high = 1'b0;
      to_low  = 1'b0;
      unique case (state)
         STABLE_LOW:  to_high = s2 && ONE_SHOT;
         WAIT_HIGH:   to_high = s2 && (cnt == LAST);
         STABLE_HIGH: to_low  = !s2 && ONE_SHOT;
         WAIT_LOW:    to_low  = !s2 && (cnt == LAST);
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= STABLE_LOW;
         cnt   <= '0;
         q     <= 1'b0;
      end else begin
         unique case (state)
            STABLE_LOW: begin
               if (to_high) begin
                  state <= STABLE_HIGH;
                  q     <= 1'b1;
               end else if (s2) begin
                  state <= WAIT_HIGH;
                  cnt   <= CNT_W'(1);
               end
            end
            WAIT_HIGH: begin
               if (to_high) begin
                  state <= STABLE_HIGH;
                  cnt   <= '0;
                  q     <= 1'b1;
               end else if (s2) begin
                  cnt <= cnt + CNT_W'(1);
               end else begin
                  state <= STABLE_LOW;
                  cnt   <= '0;
               end
            end
            STABLE_HIGH: begin
               if (to_low) begin
                  state <= STABLE_LOW;
                  q     <= 1'b0;
               end else if (!s2) begin
                  state <= WAIT_LOW;
                  cnt   <= CNT_W'(1);
               end
            end
            WAIT_LOW: begin
               if (to_low) begin
                  state <= STABLE_LOW;
                  cnt   <= '0;
                  q     <= 1'b0;
               end else if (!s2) begin
                  cnt <= cnt + CNT_W'(1);
               end else begin
                  state <= STABLE_HIGH;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= STABLE_LOW;
               cnt   <= '0;
               q     <= 1'b0;
            end
         endcase
      end
   end

`ifdef SYNC_DEBOUNCE_EDGE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= to_high;
         fall <= to_low;
      end
   end
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Randomized bench for sync_debounce against a sample-window model,
// plus hand-timed checks for reset, glitch, bounce and mid-count reset.
module tb_sync_debounce;

   localparam int SC = 4;
`ifdef SYNC_DEBOUNCE_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b1;
   logic q;
   logic rise;
   logic fall;

   int n_chk  = 0;
   int n_pass = 0;

   sync_debounce #(.STABLE_CYCLES(SC), .CNT_W(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .q    (q),
      .rise (rise),
      .fall (fall)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic got, input logic exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
   endtask

   // Model: the level flips once the last SC synchronized samples all
   // disagree with it; samples reach the filter two edges after capture.
   bit p0, p1, mq, mr, mf;
   bit hist[$];

   always @(posedge clk or posedge rst) begin
      bit samp;
      bit flip;
      if (rst) begin
         p0 = 0; p1 = 0; mq = 0; mr = 0; mf = 0;
         hist.delete();
      end else begin
         samp = p1;
         p1   = p0;
         p0   = din;
         hist.push_back(samp);
         if (hist.size() > SC) void'(hist.pop_front());
         flip = (hist.size() == SC);
         foreach (hist[i]) if (hist[i] == mq) flip = 0;
         mr = 0;
         mf = 0;
         if (flip) begin
            mq = !mq;
            mr = EDGE && mq;
            mf = EDGE && !mq;
         end
      end
   end

   always @(negedge clk) begin
      check("q", q, mq);
      check("rise", rise, mr);
      check("fall", fall, mf);
      check("excl", rise & fall, 1'b0);
   end

   initial begin
      int v;
      int len;
      // Reset held with din=1, released at 25 ns.
      @(negedge clk);
      check("rst_q", q, 1'b0);
      check("rst_rise", rise, 1'b0);
      #5 rst = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rise_q", q, 1'b0);
      @(negedge clk);
      check("t140_q", q, 1'b1);
      check("t140_rise", rise, EDGE);
      @(negedge clk);
      check("t160_rise", rise, 1'b0);
      check("t160_q", q, 1'b1);

      // Glitch of two clocks from a low level.
      din = 1'b0;
      repeat (8) @(negedge clk);
      check("low_q", q, 1'b0);
      din = 1'b1;
      repeat (2) @(negedge clk);
      din = 1'b0;
      repeat (8) @(negedge clk);
      check("glitch_q", q, 1'b0);

      // Bounce every cycle, then hold high.
      for (int i = 0; i < 10; i++) begin
         din = (i % 2 == 0);
         @(negedge clk);
      end
      check("bounce_q", q, 1'b0);
      din = 1'b1;
      repeat (5) @(negedge clk);
      check("hold5_q", q, 1'b0);
      @(negedge clk);
      check("hold6_q", q, 1'b1);
      check("hold6_rise", rise, EDGE);

      // Fall interrupted by reset mid-count.
      din = 1'b0;
      repeat (2) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst_q", q, 1'b0);
      check("midrst_fall", fall, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("after_rst_q", q, 1'b0);

      // Random runs with occasional asynchronous reset pulses.
      for (int r = 0; r < 300; r++) begin
         v   = $urandom_range(0, 1);
         len = $urandom_range(1, 8);
         din = v[0];
         if ($urandom_range(0, 39) == 0) begin
            #3 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         repeat (len) @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
